// File: rtl/complex_multiplier_param.sv
// complex_multiplier_param: iterative signed complex multiplier, P = X * Y.
// One shared shift-add multiplier computes the four W x W partial products
// serially (W cycles each) into real/imag accumulators. Latency 4*W+1 cycles.
// Optional build macro CPLX_CONJ_EN adds input conj_y selecting X * conj(Y).
module complex_multiplier_param #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef CPLX_CONJ_EN
  input  logic             conj_y,
`endif
  input  logic [2*W-1:0]   x_in,
  input  logic [2*W-1:0]   y_in,
  output logic             ready,
  output logic             done,
  output logic [2*W:0]     res_re,
  output logic [2*W:0]     res_im
);

  localparam int unsigned OUT_W = 2 * W + 1;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CW    = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd2} state_t;

  state_t state, state_nxt;

  logic signed [W-1:0]     a, b, c, d;
  logic                    conj_q;
  logic signed [OUT_W-1:0] rr, ir;
  logic signed [PW-1:0]    p;
  logic [CW-1:0]           cnt;
  logic [1:0]              idx;

  logic                    last_bit;
  logic                    load, step, fin;
  logic                    ready_d, done_d;
  logic signed [W-1:0]     mcand, mplier;
  logic                    sub, to_im;
  logic signed [PW-1:0]    mcand_ext, pp, p_sum;
  logic signed [OUT_W-1:0] prod_ext;

  assign last_bit = (cnt == CW'(W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (idx == 2'd3 && last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode and next values of the registered handshake outputs
  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_nxt == IDLE);
    case (state)
      IDLE:    load = start;
      MUL:     step = 1'b1;
      FIN:     begin fin = 1'b1; done_d = 1'b1; end
      default: ;
    endcase
  end

  // Partial-product schedule: ac, bd, ad, bc; conj flips the signs of bd and ad
  always_comb begin
    mcand  = a;
    mplier = c;
    sub    = 1'b0;
    to_im  = 1'b0;
    case (idx)
      2'd0:    begin mcand = a; mplier = c; end
      2'd1:    begin mcand = b; mplier = d; sub = ~conj_q; end
      2'd2:    begin mcand = a; mplier = d; to_im = 1'b1; sub = conj_q; end
      default: begin mcand = b; mplier = c; to_im = 1'b1; end
    endcase
  end

  // One shift-add step; the multiplier MSB carries negative weight
  always_comb begin
    mcand_ext = {{W{mcand[W-1]}}, mcand};
    pp        = mplier[cnt] ? (mcand_ext << cnt) : '0;
    p_sum     = last_bit ? (p - pp) : (p + pp);
    prod_ext  = {p_sum[PW-1], p_sum};
  end

  // Operand capture, iterative multiply and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      conj_q <= 1'b0;
      rr     <= '0;
      ir     <= '0;
      p      <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else if (load) begin
      a      <= x_in[2*W-1:W];
      b      <= x_in[W-1:0];
      c      <= y_in[2*W-1:W];
      d      <= y_in[W-1:0];
`ifdef CPLX_CONJ_EN
      conj_q <= conj_y;
`else
      conj_q <= 1'b0;
`endif
      rr     <= '0;
      ir     <= '0;
      p      <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else if (step) begin
      if (last_bit) begin
        if (to_im) ir <= sub ? (ir - prod_ext) : (ir + prod_ext);
        else       rr <= sub ? (rr - prod_ext) : (rr + prod_ext);
        p   <= '0;
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        p   <= p_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Registered outputs: handshake flags and result hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      res_re <= '0;
      res_im <= '0;
    end else begin
      ready <= ready_d;
      done  <= done_d;
      if (fin) begin
        res_re <= rr;
        res_im <= ir;
      end
    end
  end

endmodule

// File: tb/tb_complex_multiplier_param.sv
// Bench for complex_multiplier_param: directed and random operations checked
// against an integer complex-arithmetic reference model.
module tb_complex_multiplier_param;

  localparam int unsigned W   = 8;
  localparam int          LAT = 4 * W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2*W-1:0]   x_in, y_in;
  logic             ready, done;
  logic [2*W:0]     res_re, res_im;
`ifdef CPLX_CONJ_EN
  logic             conj_y;
`endif

  int checks = 0;
  int errors = 0;

  complex_multiplier_param #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef CPLX_CONJ_EN
    .conj_y(conj_y),
`endif
    .x_in(x_in),
    .y_in(y_in),
    .ready(ready),
    .done(done),
    .res_re(res_re),
    .res_im(res_im)
  );

  always #5 clk = ~clk;

  // Reference: plain complex arithmetic on integers
  function automatic void model(input int a, input int b, input int c, input int d,
                                input bit cj, output int re, output int im);
    if (cj) begin
      re = a * c + b * d;
      im = b * c - a * d;
    end else begin
      re = a * c - b * d;
      im = a * d + b * c;
    end
  endfunction

  function automatic int rnd_part();
    int v;
    v = int'($urandom_range(0, (1 << W) - 1));
    return v - (1 << (W - 1));
  endfunction

  task automatic set_ops(input int a, input int b, input int c, input int d, input bit cj);
    x_in = {W'(a), W'(b)};
    y_in = {W'(c), W'(d)};
`ifdef CPLX_CONJ_EN
    conj_y = cj;
`else
    if (cj) $display("note: conj requested in a non-conj build");
`endif
  endtask

  // Launch one op; lat = edges from accept to done (-1 on timeout)
  task automatic run_op(input int a, input int b, input int c, input int d, input bit cj,
                        output int lat, output bit ready_bad);
    @(negedge clk);
    set_ops(a, b, c, d, cj);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    ready_bad = ready;
    @(negedge clk);
    start = 1'b0;
    x_in = '1;
    y_in = '1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = k; break; end
      if (ready) ready_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lat; bit rb;
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
`ifdef CPLX_CONJ_EN
    conj_y = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || res_re !== '0 || res_im !== '0) begin
      errors++;
      $display("FAIL reset_init: ready=%b done=%b re=%0d im=%0d, want 1 0 0 0", ready, done, res_re, res_im);
    end
    // Get non-zero results, then reset asynchronously mid-cycle during a new op
    run_op(3, 4, 5, -2, 1'b0, lat, rb);
    @(negedge clk); set_ops(7, 7, 7, 7, 1'b0); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || res_re !== '0 || res_im !== '0) begin
      errors++;
      $display("FAIL reset_async: ready=%b done=%b re=%0d im=%0d, want 1 0 0 0", ready, done, res_re, res_im);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit rb;
    run_op(3, 4, 5, -2, 1'b0, lat, rb);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if ($signed(res_re) !== 23 || $signed(res_im) !== 14) begin
      errors++; $display("FAIL basic_result: got %0d,%0d want 23,14", $signed(res_re), $signed(res_im));
    end
    checks++;
    if (rb !== 1'b0) begin errors++; $display("FAIL basic_ready_low: ready high during op"); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_done: got %b want 1", ready); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || $signed(res_re) !== 23) begin
      errors++; $display("FAIL basic_done_pulse: done=%b re=%0d want 0,23", done, $signed(res_re));
    end
  endtask

  task automatic test_extreme();
    int lat; bit rb;
    run_op(-128, -128, -128, -128, 1'b0, lat, rb);
    checks++;
    if ($signed(res_re) !== 0 || $signed(res_im) !== 32768) begin
      errors++; $display("FAIL extreme_both: got %0d,%0d want 0,32768", $signed(res_re), $signed(res_im));
    end
    run_op(-128, 0, -128, 0, 1'b0, lat, rb);
    checks++;
    if ($signed(res_re) !== 16384 || $signed(res_im) !== 0) begin
      errors++; $display("FAIL extreme_real: got %0d,%0d want 16384,0", $signed(res_re), $signed(res_im));
    end
  endtask

  task automatic test_back_to_back();
    int re, im, lat;
    bit seen;
    @(negedge clk);
    set_ops(-5, 9, 12, -7, 1'b0);
    model(-5, 9, 12, -7, 1'b0, re, im);
    start = 1'b1;
    @(posedge clk);
    seen = 1'b0; lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      x_in = 16'($urandom); y_in = 16'($urandom);
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; lat = k; break; end
    end
    checks++;
    if (!seen || lat !== LAT || $signed(res_re) !== re || $signed(res_im) !== im) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d got %0d,%0d want lat %0d %0d,%0d", lat, $signed(res_re), $signed(res_im), LAT, re, im);
    end
    // Start still high in the done cycle: new op accepted at the next edge
    @(negedge clk);
    set_ops(1, 1, 1, -1, 1'b0);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat !== LAT || $signed(res_re) !== 2 || $signed(res_im) !== 0) begin
      errors++; $display("FAIL b2b_second: lat=%0d got %0d,%0d want %0d 2,0", lat, $signed(res_re), $signed(res_im), LAT);
    end
  endtask

  task automatic test_reset_midop();
    int lat; bit rb; bit bad;
    @(negedge clk); set_ops(11, -3, 4, 8, 1'b0); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (done) bad = 1'b1; end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin @(posedge clk); #1; if (done) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL midop_no_done: done pulse seen after abort"); end
    run_op(-1, 2, 7, 3, 1'b0, lat, rb);
    checks++;
    if (lat !== LAT || $signed(res_re) !== -13 || $signed(res_im) !== 11) begin
      errors++; $display("FAIL midop_fresh: lat=%0d got %0d,%0d want %0d -13,11", lat, $signed(res_re), $signed(res_im), LAT);
    end
  endtask

  task automatic test_random();
    int a, b, c, d, re, im, lat; bit rb, cj;
    for (int n = 0; n < 25; n++) begin
      a = rnd_part(); b = rnd_part(); c = rnd_part(); d = rnd_part();
`ifdef CPLX_CONJ_EN
      cj = 1'($urandom_range(0, 1));
`else
      cj = 1'b0;
`endif
      model(a, b, c, d, cj, re, im);
      run_op(a, b, c, d, cj, lat, rb);
      checks++;
      if (lat !== LAT || rb || $signed(res_re) !== re || $signed(res_im) !== im) begin
        errors++;
        $display("FAIL random_%0d: (%0d,%0d)*(%0d,%0d) cj=%0d lat=%0d got %0d,%0d want %0d,%0d",
                 n, a, b, c, d, cj, lat, $signed(res_re), $signed(res_im), re, im);
      end
    end
  endtask

`ifdef CPLX_CONJ_EN
  task automatic test_conj();
    int lat; bit rb;
    run_op(3, 4, 5, -2, 1'b1, lat, rb);
    checks++;
    if (lat !== LAT || $signed(res_re) !== 7 || $signed(res_im) !== 26) begin
      errors++; $display("FAIL conj_on: lat=%0d got %0d,%0d want %0d 7,26", lat, $signed(res_re), $signed(res_im), LAT);
    end
    run_op(3, 4, 5, -2, 1'b0, lat, rb);
    checks++;
    if ($signed(res_re) !== 23 || $signed(res_im) !== 14) begin
      errors++; $display("FAIL conj_off: got %0d,%0d want 23,14", $signed(res_re), $signed(res_im));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_back_to_back();
    test_reset_midop();
`ifdef CPLX_CONJ_EN
    test_conj();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
